// File: rtl/clock_switch_ctrl_pkg.sv
// Shared types and helpers for the clock switch sequencer.
package clock_switch_pkg;

  // Widest select bus the onehot helper can build.
  localparam int unsigned MAX_N = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_SETTLE = 2'd2
  } state_e;

  // One-hot vector with bit 'index' set; all-zero when index is out of range.
  function automatic logic [MAX_N-1:0] onehot(input int unsigned index, input int unsigned n);
    logic [MAX_N-1:0] v;
    v = '0;
    if (index < n && index < MAX_N) begin
      v = {{(MAX_N-1){1'b0}}, 1'b1} << index;
    end
    return v;
  endfunction

endpackage

// File: rtl/clock_switch_ctrl_if.sv
// Request handshake between a requester and the clock switch sequencer.
interface clock_switch_ctrl_if #(
  parameter int unsigned SEL_W = 1
) ();
  logic             req_valid;
  logic             req_ready;
  logic [SEL_W-1:0] req_sel;

  modport master (output req_valid, output req_sel, input req_ready);
  modport slave  (input req_valid, input req_sel, output req_ready);
endinterface

// File: rtl/clock_switch_ctrl_cycle_timer.sv
// Loadable down-counter that stops at zero.
module cycle_timer #(
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic [CNT_W-1:0] value_o,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Load takes priority; otherwise count down and hold at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= CNT_W'(RESET_VAL);
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign value_o = cnt_q;
  assign zero_o  = (cnt_q == '0);

endmodule

// File: rtl/clock_switch_ctrl.sv
// Sequences the one-hot select of a glitch-free clock mux: drain, select, settle,
// with automatic fallback to the default clock when the active one goes bad.
module clock_switch_ctrl
  import clock_switch_pkg::*;
#(
  parameter int unsigned N             = 2,
  parameter int unsigned SEL_W         = 1,
  parameter int unsigned DEFAULT_SEL   = 0,
  parameter int unsigned DRAIN_CYCLES  = 16,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned CNT_W         = 8
) (
  input  logic                clk,
  input  logic                rstb,
  clock_switch_ctrl_if.slave  req_if,
  input  logic [N-1:0]        clk_ok,
  output logic [N-1:0]        select,
  output logic [SEL_W-1:0]    current_sel,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic                fallback
);

  localparam logic [SEL_W-1:0] DefSel = SEL_W'(DEFAULT_SEL);
  localparam logic [N-1:0]     DefOh  = N'(onehot(DEFAULT_SEL, N));

  state_e           state_q, state_d;
  logic [N-1:0]     select_q, select_d;
  logic [SEL_W-1:0] cur_q, cur_d;
  logic [SEL_W-1:0] target_q, target_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             fb_q, fb_d;
  // Set by reset so the reset-time settle ends without a done pulse.
  logic             init_q, init_d;

  logic             tmr_load;
  logic [CNT_W-1:0] tmr_load_val;
  logic [CNT_W-1:0] tmr_value;
  logic             tmr_zero;

  logic cur_ok, req_ok, def_ok, fb_cond;

  cycle_timer #(
    .CNT_W     (CNT_W),
    .RESET_VAL (SETTLE_CYCLES - 1)
  ) u_timer (
    .clk_i      (clk),
    .rst_ni     (rstb),
    .load_i     (tmr_load),
    .load_val_i (tmr_load_val),
    .value_o    (tmr_value),
    .zero_o     (tmr_zero)
  );

  // Health lookups; an out-of-range request index never matches, so it reads as not ok.
  always_comb begin
    cur_ok = 1'b0;
    req_ok = 1'b0;
    def_ok = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (cur_q == SEL_W'(i))          cur_ok = clk_ok[i];
      if (req_if.req_sel == SEL_W'(i)) req_ok = clk_ok[i];
      if (i == DEFAULT_SEL)            def_ok = clk_ok[i];
    end
    fb_cond = !cur_ok && (cur_q != DefSel) && def_ok;
  end

  assign req_if.req_ready = (state_q == ST_IDLE) && !fb_cond;

  // Next-state, select sequencing and pulse generation.
  always_comb begin
    state_d      = state_q;
    select_d     = select_q;
    cur_d        = cur_q;
    target_d     = target_q;
    done_d       = 1'b0;
    err_d        = 1'b0;
    fb_d         = 1'b0;
    init_d       = init_q;
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (fb_cond) begin
          target_d     = DefSel;
          fb_d         = 1'b1;
          state_d      = ST_DRAIN;
          select_d     = '0;
          tmr_load     = 1'b1;
          tmr_load_val = CNT_W'(DRAIN_CYCLES - 1);
        end else if (req_if.req_valid) begin
          if (!req_ok) begin
            err_d = 1'b1;
          end else if (req_if.req_sel == cur_q) begin
            done_d = 1'b1;
          end else begin
            target_d     = req_if.req_sel;
            state_d      = ST_DRAIN;
            select_d     = '0;
            tmr_load     = 1'b1;
            tmr_load_val = CNT_W'(DRAIN_CYCLES - 1);
          end
        end
      end
      ST_DRAIN: begin
        if (tmr_zero) begin
          state_d      = ST_SETTLE;
          select_d     = N'(onehot(int'(target_q), N));
          tmr_load     = 1'b1;
          tmr_load_val = CNT_W'(SETTLE_CYCLES - 1);
        end
      end
      ST_SETTLE: begin
        if (tmr_zero) begin
          state_d = ST_IDLE;
          cur_d   = target_q;
          done_d  = !init_q;
          init_d  = 1'b0;
        end
      end
      default: state_d = ST_SETTLE;
    endcase
  end

  // State and output registers; reset restarts a settle on the default clock.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q  <= ST_SETTLE;
      select_q <= DefOh;
      cur_q    <= DefSel;
      target_q <= DefSel;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      fb_q     <= 1'b0;
      init_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      select_q <= select_d;
      cur_q    <= cur_d;
      target_q <= target_d;
      done_q   <= done_d;
      err_q    <= err_d;
      fb_q     <= fb_d;
      init_q   <= init_d;
    end
  end

  assign select      = select_q;
  assign current_sel = cur_q;
  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;
  assign err         = err_q;
  assign fallback    = fb_q;

endmodule

// File: tb/tb_clock_switch_ctrl.sv
// Directed bench for clock_switch_ctrl with N=2, SEL_W=2, 16-cycle drain and settle.
module tb_clock_switch_ctrl;

  logic       clk;
  logic       rstb;
  logic [1:0] clk_ok;
  logic [1:0] select;
  logic [1:0] current_sel;
  logic       busy, done, err, fallback;

  int checks = 0;
  int errors = 0;

  clock_switch_ctrl_if #(.SEL_W(2)) req_if ();

  clock_switch_ctrl #(
    .N             (2),
    .SEL_W         (2),
    .DEFAULT_SEL   (0),
    .DRAIN_CYCLES  (16),
    .SETTLE_CYCLES (16),
    .CNT_W         (8)
  ) dut (
    .clk         (clk),
    .rstb        (rstb),
    .req_if      (req_if),
    .clk_ok      (clk_ok),
    .select      (select),
    .current_sel (current_sel),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .fallback    (fallback)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // After a reset release: 16 cycles busy on select 01, then idle with no done pulse.
  task automatic check_reset_settle(input string tag);
    int bad = 0;
    @(negedge clk);
    rstb = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      step();
      if (busy !== 1'b1 || select !== 2'b01 || req_if.req_ready !== 1'b0 || done !== 1'b0)
        bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL %s_settle: %0d bad cycles, required 0", tag, bad);
    end
    step();
    checks++;
    if (busy !== 1'b0 || req_if.req_ready !== 1'b1 || current_sel !== 2'd0 || done !== 1'b0) begin
      errors++;
      $display("FAIL %s_exit: busy=%b ready=%b cur=%0d done=%b, required 0 1 0 0",
               tag, busy, req_if.req_ready, current_sel, done);
    end
  endtask

  // Accept edge already taken: check 16 drain cycles, 16 settle cycles on exp_sel, then done.
  task automatic check_sequence(input string tag, input logic [1:0] exp_sel,
                                input logic [1:0] exp_cur);
    int bad_drain = 0;
    int bad_settle = 0;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) step();
      if (select !== 2'b00 || busy !== 1'b1 || done !== 1'b0 || err !== 1'b0) bad_drain++;
    end
    for (int i = 0; i < 16; i++) begin
      step();
      if (select !== exp_sel || busy !== 1'b1 || done !== 1'b0) bad_settle++;
    end
    checks++;
    if (bad_drain !== 0) begin
      errors++;
      $display("FAIL %s_drain: %0d bad cycles, required 0", tag, bad_drain);
    end
    checks++;
    if (bad_settle !== 0) begin
      errors++;
      $display("FAIL %s_settle: %0d bad cycles, required 0", tag, bad_settle);
    end
    step();
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || current_sel !== exp_cur || select !== exp_sel) begin
      errors++;
      $display("FAIL %s_done: done=%b busy=%b cur=%0d sel=%b, required 1 0 %0d %b",
               tag, done, busy, current_sel, select, exp_cur, exp_sel);
    end
    step();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL %s_done_pulse: done=%b, required 0", tag, done);
    end
  endtask

  task automatic test_reset();
    rstb = 1'b0;
    req_if.req_valid = 1'b0;
    req_if.req_sel = 2'd0;
    clk_ok = 2'b11;
    repeat (3) step();
    checks++;
    if (select !== 2'b01 || busy !== 1'b1 || req_if.req_ready !== 1'b0 || current_sel !== 2'd0 ||
        done !== 1'b0 || err !== 1'b0 || fallback !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: sel=%b busy=%b ready=%b cur=%0d d/e/f=%b%b%b, required 01 1 0 0 000",
               select, busy, req_if.req_ready, current_sel, done, err, fallback);
    end
    check_reset_settle("reset");
  endtask

  task automatic test_same_sel();
    req_if.req_valid = 1'b1;
    req_if.req_sel = 2'd0;
    step();
    req_if.req_valid = 1'b0;
    checks++;
    if (done !== 1'b1 || select !== 2'b01 || busy !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL same_sel: done=%b sel=%b busy=%b err=%b, required 1 01 0 0",
               done, select, busy, err);
    end
    step();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL same_sel_pulse: done=%b, required 0", done);
    end
  endtask

  task automatic test_err();
    clk_ok = 2'b01;
    req_if.req_valid = 1'b1;
    req_if.req_sel = 2'd1;
    step();
    checks++;
    if (err !== 1'b1 || select !== 2'b01 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL err_bad_clk: err=%b sel=%b busy=%b done=%b, required 1 01 0 0",
               err, select, busy, done);
    end
    clk_ok = 2'b11;
    req_if.req_sel = 2'd2;
    step();
    req_if.req_valid = 1'b0;
    checks++;
    if (err !== 1'b1 || select !== 2'b01 || busy !== 1'b0 || current_sel !== 2'd0) begin
      errors++;
      $display("FAIL err_range: err=%b sel=%b busy=%b cur=%0d, required 1 01 0 0",
               err, select, busy, current_sel);
    end
    step();
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_pulse: err=%b, required 0", err);
    end
  endtask

  task automatic test_switch();
    req_if.req_valid = 1'b1;
    req_if.req_sel = 2'd1;
    #1;
    checks++;
    if (req_if.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL switch_ready: ready=%b, required 1", req_if.req_ready);
    end
    step();
    req_if.req_valid = 1'b0;
    check_sequence("switch", 2'b10, 2'd1);
  endtask

  task automatic test_fallback();
    clk_ok = 2'b01;
    req_if.req_valid = 1'b1;
    req_if.req_sel = 2'd1;
    #1;
    checks++;
    if (req_if.req_ready !== 1'b0) begin
      errors++;
      $display("FAIL fb_ready: ready=%b, required 0", req_if.req_ready);
    end
    step();
    req_if.req_valid = 1'b0;
    checks++;
    if (fallback !== 1'b1 || err !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL fb_pulse: fb=%b err=%b done=%b, required 1 0 0", fallback, err, done);
    end
    check_sequence("fallback", 2'b01, 2'd0);
    clk_ok = 2'b11;
  endtask

  // Active clock 1 bad while the default is also bad: stay put, still take requests.
  task automatic test_no_fallback();
    int bad = 0;
    req_if.req_valid = 1'b1;
    req_if.req_sel = 2'd1;
    step();
    req_if.req_valid = 1'b0;
    check_sequence("to1", 2'b10, 2'd1);
    clk_ok = 2'b00;
    for (int i = 0; i < 5; i++) begin
      step();
      if (fallback !== 1'b0 || busy !== 1'b0 || req_if.req_ready !== 1'b1 || select !== 2'b10) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL no_fallback: %0d bad cycles, required 0", bad);
    end
    clk_ok = 2'b11;
  endtask

  task automatic test_reset_mid_drain();
    req_if.req_valid = 1'b1;
    req_if.req_sel = 2'd0;
    step();
    req_if.req_valid = 1'b0;
    repeat (5) step();
    rstb = 1'b0;
    #1;
    checks++;
    if (select !== 2'b01 || busy !== 1'b1 || current_sel !== 2'd0 || req_if.req_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: sel=%b busy=%b cur=%0d ready=%b, required 01 1 0 0",
               select, busy, current_sel, req_if.req_ready);
    end
    check_reset_settle("mid_reset");
  endtask

  initial begin
    test_reset();
    test_same_sel();
    test_err();
    test_switch();
    test_fallback();
    test_no_fallback();
    test_reset_mid_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clock_switch_ctrl.md
Name: clock_switch_ctrl

Overview:
Sequencer that drives the one-hot `select` bus of the downstream glitch-free clock mux from a single always-on reference clock. It accepts clock-change requests over a valid/ready handshake and enforces a deselect-all drain window before asserting the new select. It then holds a settle window before reporting completion, and falls back automatically to a default clock when the active clock is flagged bad.

Parameters:
N, 2, number of selectable clocks (>=2)
SEL_W, 1, width of clock index (>= clog2(N))
DEFAULT_SEL, 0, index selected out of reset and on fallback (< N)
DRAIN_CYCLES, 16, cycles with select all-zero before new select (>= 1; covers mux resync latency of slowest clock)
SETTLE_CYCLES, 16, cycles new select is held before done (>= 1)
CNT_W, 8, timer width; must hold max(DRAIN_CYCLES, SETTLE_CYCLES)-1

Ports:
clk  input  1  always-on reference clock
rstb  input  1  asynchronous active-low reset
req_valid  input  1  switch request valid
req_ready  output  1  request accepted when req_valid & req_ready at posedge clk
req_sel  input  SEL_W  requested clock index
clk_ok  input  N  per-clock health, synchronous to clk (from clock monitor)
select  output  N  one-hot or all-zero select to clock mux, registered
current_sel  output  SEL_W  index of last completed selection
busy  output  1  switch sequence in progress
done  output  1  one-cycle pulse: switch complete (or no-op accepted)
err  output  1  one-cycle pulse: request rejected
fallback  output  1  one-cycle pulse: automatic fallback started

Behaviour:
- States: SETTLE, IDLE, DRAIN. Reset enters SETTLE: select=onehot(DEFAULT_SEL), current_sel=DEFAULT_SEL, busy=1, timer=SETTLE_CYCLES-1, done/err/fallback=0, req_ready=0.
- req_ready = (state==IDLE) && !fb_cond, combinational; fb_cond = !clk_ok[current_sel] && current_sel!=DEFAULT_SEL && clk_ok[DEFAULT_SEL].
- IDLE, fb_cond: target=DEFAULT_SEL, fallback pulse next cycle, go DRAIN. This takes priority over req_valid; the request is not accepted that cycle.
- IDLE, accept, req_sel>=N or !clk_ok[req_sel]: err=1 next cycle, state/select unchanged.
- IDLE, accept, req_sel==current_sel (valid, ok): done=1 next cycle, no DRAIN, select unchanged.
- IDLE, accept otherwise: target=req_sel, go DRAIN.
- DRAIN: select=0 from the first cycle after acceptance. Timer loads DRAIN_CYCLES-1 and decrements. Select is zero for exactly DRAIN_CYCLES cycles. At timer==0, go SETTLE with select=onehot(target) and timer=SETTLE_CYCLES-1.
- SETTLE: select=onehot(target) for exactly SETTLE_CYCLES cycles. At timer==0, go IDLE: current_sel=target, done pulse, busy=0 (same edge).
- The end-to-end path is acceptance edge t to done high at t+DRAIN_CYCLES+SETTLE_CYCLES.
- busy=1 in DRAIN and SETTLE; 0 in IDLE.
- clk_ok is ignored in DRAIN/SETTLE. A bad target is caught by fb_cond on return to IDLE.
- If clk_ok[DEFAULT_SEL]=0, no fallback occurs; the block stays in IDLE on the bad clock. Requests to other ok clocks are still honoured.
- select is never multi-hot. It changes only at a DRAIN entry (to 0) or a SETTLE entry (to one-hot).
- Reset assertion mid-sequence returns all outputs to their reset values immediately (async). The reset SETTLE then runs.
- done, err and fallback are mutually exclusive per cycle.

Decomposition:
- Shared package `clock_switch_pkg`: state encoding constants (ST_IDLE, ST_DRAIN, ST_SETTLE), onehot(index,N) function.
- One sub-module, `cycle_timer`: a loadable CNT_W down-counter with load, value and zero flag.
- The FSM, handshake and fallback logic stay in clock_switch_ctrl.

Test Plan:
- Reset release, N=2, defaults: select=2'b01 and busy=1 for 16 cycles. Then busy=0, req_ready=1, current_sel=0; no done pulse at reset exit.
- Request req_sel=1 accepted at t: select=00 for t+1..t+16, select=10 for t+17..t+32. done=1 and current_sel=1 at t+32, busy low the same cycle.
- Request req_sel=0 when current_sel=0: done pulse at t+1; select, busy unchanged.
- Request req_sel=1 with clk_ok=2'b01: err pulse at t+1, select stays 01. Request req_sel=2 with N=2, SEL_W=2: err pulse at t+1, select unchanged.
- In IDLE on clock 1, drop clk_ok[1] while req_valid=1 with req_sel=1: req_ready=0, fallback pulse next cycle. Drain 16, select=01 for 16, then done with current_sel=0.
- Assert rstb low mid-DRAIN: select=onehot(0) and busy=1 immediately. After release, a full 16-cycle SETTLE runs before req_ready=1.
